// File: rtl/key_display_pkg.sv
// Shared types and constants for key_event_display: mux FSM states and
// active-low seven-segment glyphs in {g,f,e,d,c,b,a} order.
package key_display_pkg;

  typedef enum logic [1:0] {
    StShowR,
    StBlankToL,
    StShowL,
    StBlankToR
  } mux_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Packed so that HEX_GLYPHS[n] is the glyph for hex value n (entry 0 is rightmost).
  localparam logic [15:0][6:0] HEX_GLYPHS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational hex to active-low seven-segment decoder, {g,f,e,d,c,b,a}.
module sevenseg_decoder
  import key_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPHS[hex];

endmodule

// File: rtl/key_event_display.sv
// Key-event consumer: shifts digits into a two-digit history and multiplexes two
// common-anode displays with dead-time. Optional KEY_DISPLAY_BLANK_EN blanks unset digits.
module key_event_display
  import key_display_pkg::*;
#(
  parameter logic [23:0] MUX_DIVIDER  = 24'd48000,
  parameter logic [7:0]  BLANK_CYCLES = 8'd48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_key,
  input  logic [3:0] digit,
  output logic [6:0] seg,
  output logic       an_left,
  output logic       an_right
);

  mux_state_t  state_q;
  logic [23:0] count_q;
  logic [23:0] limit;
  logic        valid_q;
  logic [3:0]  left_q;
  logic [3:0]  right_q;
  logic        key_event;
  logic [3:0]  sel_digit;
  logic [6:0]  glyph;
  logic        sel_vld;

  assign key_event = valid_key & ~valid_q;

`ifdef KEY_DISPLAY_BLANK_EN
  logic left_vld_q;
  logic right_vld_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_vld_q  <= 1'b0;
      right_vld_q <= 1'b0;
    end else if (key_event) begin
      left_vld_q  <= right_vld_q;
      right_vld_q <= 1'b1;
    end
  end

  assign sel_vld = (state_q == StShowL) ? left_vld_q : right_vld_q;
`else
  assign sel_vld = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      left_q  <= 4'h0;
      right_q <= 4'h0;
    end else begin
      valid_q <= valid_key;
      if (key_event) begin
        left_q  <= right_q;
        right_q <= digit;
      end
    end
  end

  always_comb begin
    limit = MUX_DIVIDER;
    if (state_q == StBlankToL || state_q == StBlankToR) begin
      limit = {16'd0, BLANK_CYCLES};
    end
  end

  // Counter restarts from zero on every phase change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StShowR;
      count_q <= 24'd0;
    end else if (count_q == limit - 24'd1) begin
      count_q <= 24'd0;
      unique case (state_q)
        StShowR:    state_q <= StBlankToL;
        StBlankToL: state_q <= StShowL;
        StShowL:    state_q <= StBlankToR;
        StBlankToR: state_q <= StShowR;
        default:    state_q <= StShowR;
      endcase
    end else begin
      count_q <= count_q + 24'd1;
    end
  end

  assign an_right  = (state_q == StShowR);
  assign an_left   = (state_q == StShowL);
  assign sel_digit = an_left ? left_q : right_q;

  sevenseg_decoder u_decoder (
    .hex (sel_digit),
    .seg (glyph)
  );

  always_comb begin
    seg = SEG_BLANK;
    if ((an_left || an_right) && sel_vld) begin
      seg = glyph;
    end
  end

endmodule

// File: tb/tb_key_event_display.sv
// Scoreboard bench for key_event_display: expected outputs come from a model indexed
// by cycles since reset release and a digit-history queue. Honours KEY_DISPLAY_BLANK_EN.
module tb_key_event_display;

  localparam int MD     = 4;
  localparam int BC     = 2;
  localparam int PERIOD = 2 * (MD + BC);

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       valid_key = 1'b0;
  logic [3:0] digit     = 4'h0;
  logic [6:0] seg;
  logic       an_left;
  logic       an_right;

  key_event_display #(
    .MUX_DIVIDER  (24'd4),
    .BLANK_CYCLES (8'd2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_key (valid_key),
    .digit     (digit),
    .seg       (seg),
    .an_left   (an_left),
    .an_right  (an_right)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       an_left;
    logic       an_right;
  } obs_t;

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  obs_t       exp_q[$];
  logic [3:0] hist[$];   // key history, newest at the back
  int         t;         // clock edges since reset release
  logic       prev_v;
  int         n_checks = 0;
  int         n_pass   = 0;

  function automatic void model_reset();
    hist.delete();
`ifndef KEY_DISPLAY_BLANK_EN
    hist.push_back(4'h0);
    hist.push_back(4'h0);
`endif
    t      = 0;
    prev_v = 1'b0;
  endfunction

  function automatic obs_t expect_now();
    obs_t o;
    int   p;
    p          = t % PERIOD;
    o.seg      = 7'b1111111;
    o.an_left  = 1'b0;
    o.an_right = 1'b0;
    if (p < MD) begin
      o.an_right = 1'b1;
      if (hist.size() >= 1) o.seg = glyph[hist[hist.size() - 1]];
    end else if (p >= MD + BC && p < 2 * MD + BC) begin
      o.an_left = 1'b1;
      if (hist.size() >= 2) o.seg = glyph[hist[hist.size() - 2]];
    end
    return o;
  endfunction

  task automatic compare(input string name, input obs_t e);
    n_checks++;
    if ({seg, an_left, an_right} === e) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0d: got seg=%b an_left=%b an_right=%b, want seg=%b an_left=%b an_right=%b",
               name, t, seg, an_left, an_right, e.seg, e.an_left, e.an_right);
    end
  endtask

  // Model: advances on each edge and queues what the DUT should show until the next edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        model_reset();
      end else begin
        if (valid_key && !prev_v) begin
          hist.push_back(digit);
          if (hist.size() > 2) void'(hist.pop_front());
        end
        prev_v = valid_key;
        t++;
      end
      exp_q.push_back(expect_now());
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) compare("display", exp_q.pop_front());
    end
  end

  task automatic step(input logic v, input logic [3:0] d);
    valid_key = v;
    digit     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic align(input int target);
    for (int i = 0; i < PERIOD && (t % PERIOD) != target; i++) step(1'b0, 4'h0);
    n_checks++;
    if ((t % PERIOD) == target) n_pass++;
    else $display("FAIL align: phase=%0d, want %0d", t % PERIOD, target);
  endtask

  initial begin
    model_reset();
    #1;
    compare("reset_initial", expect_now());
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(24);

    step(1'b1, 4'h3);
    idle(5);
    step(1'b1, 4'hA);
    idle(24);

    step(1'b1, 4'h5);
    repeat (4) step(1'b1, 4'h5);
    repeat (5) step(1'b1, 4'h7);
    idle(24);

    // Event sampled on the edge that leaves the last SHOW_L cycle.
    align(2 * MD + BC - 1);
    step(1'b1, 4'hC);
    idle(2 * PERIOD);

    // Asynchronous reset between edges in the middle of SHOW_L.
    step(1'b1, 4'h9);
    align(MD + BC + 1);
    #2;
    reset = 1'b0;
    exp_q.delete();
    model_reset();
    exp_q.push_back(expect_now());
    #1;
    compare("async_reset_mid", expect_now());
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    reset = 1'b1;
    idle(24);

    repeat (10000) step(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
    idle(2);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_event_display.md
# key_event_display

Consumer end of the keypad scanner's key-event interface. Accepts the one-cycle `valid_key`/`digit` event stream and shifts each new hex digit into a two-digit history, with the newest digit on the right. Drives a time-multiplexed pair of common-anode seven-segment displays, with a dead-time between digits to prevent ghosting. Sits between the keypad FSM and the board's segment/anode pins.

## Interface
- `MUX_DIVIDER`, default 24'd48000: cycles each digit is lit (1 kHz per digit at 48 MHz).
- `BLANK_CYCLES`, default 8'd48: cycles with both anodes off between digits. Legal range is ≥1.
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `valid_key`, in, 1: key event strobe. Only a rising edge counts.
- `digit`, in, 4: hex value of the key. Sampled on the rising-edge cycle of `valid_key`.
- `seg`, out, 7: active-low segments, {g,f,e,d,c,b,a}.
- `an_left`, out, 1: left digit enable, active-high.
- `an_right`, out, 1: right digit enable, active-high.

## Operation
- **Event capture.**
  - Register `valid_q` holds the previous `valid_key`. An event is `valid_key & ~valid_q`.
  - On an event: `left <= right`, `right <= digit`.
  - A held `valid_key` produces exactly one event. It must return low for ≥1 cycle before the next event.
- **Mux FSM states:** SHOW_R, BLANK_TO_L, SHOW_L, BLANK_TO_R.
  - SHOW_R: `an_right`=1, `seg`=decode(`right`). After MUX_DIVIDER cycles go to BLANK_TO_L.
  - BLANK_TO_L: both anodes 0, `seg`=7'b1111111. After BLANK_CYCLES go to SHOW_L.
  - SHOW_L: `an_left`=1, `seg`=decode(`left`). After MUX_DIVIDER cycles go to BLANK_TO_R.
  - BLANK_TO_R: both anodes 0, `seg`=7'b1111111. After BLANK_CYCLES go to SHOW_R.
- **Phase counter.**
  - 24 bits, zeroed on every state transition.
  - A transition fires when count == limit−1.
  - No other wrap behaviour is exposed.
- **Output encoding.**
  - `an_left` and `an_right` are never both 1.
  - `seg` is combinational from state plus the digit registers.
- **Decoder.**
  - Standard hex glyphs, 0–9 and A,b,C,d,E,F.
  - Examples: 0→7'b1000000, 1→7'b1111001, 8→7'b0000000, F→7'b0001110.
- **Reset values.** Asserting `reset` low clears immediately, mid-phase or mid-event:
  - `left`=`right`=0, `valid_q`=0.
  - State SHOW_R, counter 0.
  - Outputs: `an_right`=1, `an_left`=0, `seg`=7'b1000000.
- **First cycle after reset.** `valid_key` high on the first cycle after reset release counts as an event, because `valid_q` resets to 0.

## Timing
- **Event latency.** Rising edge of `valid_key` sampled at edge k → digit registers updated at edge k. If `right` is currently displayed, `seg` changes in the cycle after edge k.
- **Display period.** 2·(MUX_DIVIDER+BLANK_CYCLES) cycles. Each digit's duty cycle is MUX_DIVIDER / period.
- **Simultaneous event and phase change.** Both take effect at the same edge. The new phase displays the updated registers.
- **Back-to-back events** (high, low, high on alternating cycles): two shifts, 2 cycles apart, none lost.
- **`digit`** is ignored on any cycle that is not an event cycle.

## Configuration
- `KEY_DISPLAY_BLANK_EN`: defines one valid flag per digit register.
  - Flags clear on reset. An event sets `right_vld` and copies `right_vld` into `left_vld`.
  - A digit whose flag is 0 shows `seg`=7'b1111111 while its anode is still strobed.
  - Reset `seg` is 7'b1111111.
- Without the macro: no flags. Both digits show 0 after reset, and reset `seg`=7'b1000000.

## Structure
- Package `key_display_pkg`:
  - `mux_state_t` enum.
  - `SEG_BLANK` = 7'b1111111.
  - The 16-entry hex glyph constants.
- Sub-module `sevenseg_decoder`: combinational, 4-bit in → 7-bit active-low out. Instantiated once, fed by a digit-select mux.
- Top-level contents: event edge detector, digit shift registers, FSM, phase counter.

## Test plan
Benches use MUX_DIVIDER=4, BLANK_CYCLES=2.
- **Reset:** hold `reset`=0, release, watch 24 cycles → `an_right`=1 for 4 cycles, both anodes 0 for 2, `an_left`=1 for 4, both 0 for 2, repeating. `seg`=7'b1000000 whenever an anode is on (7'b1111111 with `KEY_DISPLAY_BLANK_EN`).
- **Two events:** pulse `valid_key` 1 cycle with `digit`=4'h3, later with 4'hA → `right`=A shows 7'b0001000, `left`=3 shows 7'b0110000.
- **Held strobe:** hold `valid_key` high 10 cycles with `digit`=5, changing `digit` to 7 mid-hold → exactly one shift, `right`=5.
- **Coincident event:** event lands on the last SHOW_L cycle → next SHOW_R already shows the new digit, and `left` in the following SHOW_L shows the old `right`.
- **Async reset mid-phase:** drive `reset` low mid-SHOW_L between clock edges → outputs return to reset values before the next edge, and both digits clear.
- **Anode exclusion:** random events over 10k cycles → `an_left & an_right` is never 1, and `seg`=7'b1111111 whenever both anodes are 0.
